// File: rtl/mips_defs.sv
// Shared MIPS decode constants and the per-stage decode bundle
// used by the hazard/stall controller.
package mips_defs;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0a;
    localparam logic [5:0] OP_SLTIU  = 6'h0b;
    localparam logic [5:0] OP_ANDI   = 6'h0c;
    localparam logic [5:0] OP_ORI    = 6'h0d;
    localparam logic [5:0] OP_XORI   = 6'h0e;
    localparam logic [5:0] OP_LUI    = 6'h0f;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LH     = 6'h21;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_LBU    = 6'h24;
    localparam logic [5:0] OP_LHU    = 6'h25;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SH     = 6'h29;
    localparam logic [5:0] OP_SW     = 6'h2b;

    localparam logic [4:0] RT_BGEZALL = 5'h13;

    localparam logic [5:0] F_JR    = 6'h08;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1a;
    localparam logic [5:0] F_DIVU  = 6'h1b;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2a;
    localparam logic [5:0] F_SLTU  = 6'h2b;

    // T_NONE marks an operand that is never read; it can never be < Tnew
    localparam logic [1:0] T_0    = 2'd0;
    localparam logic [1:0] T_1    = 2'd1;
    localparam logic [1:0] T_2    = 2'd2;
    localparam logic [1:0] T_NONE = 2'd3;

    localparam logic [31:0] NOP = 32'h0;

    typedef struct packed {
        logic       cal_r;
        logic       cal_i;
        logic       load;
        logic       store;
        logic       beq;
        logic       bgezall;
        logic       jr;
        logic       jal;
        logic       mult;
        logic       div;
        logic       isMD;
        logic       isMfhilo;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] wdes;
    } ins_info_t;

endpackage

// File: rtl/InsJudge.sv
// Instruction class decoder; one instance per pipeline stage.
// Reports class flags, source registers and write destination.
module InsJudge
    import mips_defs::*;
(
    input  logic [31:0] ins_i,
    output ins_info_t   info_o
);

    logic [5:0] op;
    logic [5:0] fn;
    logic       rtype;
    logic       unused_shamt;

    assign op           = ins_i[31:26];
    assign fn           = ins_i[5:0];
    assign rtype        = (op == OP_RTYPE);
    assign unused_shamt = ^ins_i[10:6];

    always_comb begin
        info_o       = '0;
        info_o.rs    = ins_i[25:21];
        info_o.rt    = ins_i[20:16];
        info_o.cal_r = rtype && (fn inside {F_ADD, F_ADDU, F_SUB,
                                            F_SUBU, F_AND, F_OR,
                                            F_XOR, F_NOR, F_SLT,
                                            F_SLTU});
        info_o.cal_i = op inside {OP_ADDI, OP_ADDIU, OP_SLTI,
                                  OP_SLTIU, OP_ANDI, OP_ORI,
                                  OP_XORI, OP_LUI};
        info_o.load  = op inside {OP_LB, OP_LH, OP_LW,
                                  OP_LBU, OP_LHU};
        info_o.store = op inside {OP_SB, OP_SH, OP_SW};
        info_o.beq   = (op == OP_BEQ);
        info_o.bgezall = (op == OP_REGIMM)
                       && (ins_i[20:16] == RT_BGEZALL);
        info_o.jr    = rtype && (fn == F_JR);
        info_o.jal   = (op == OP_JAL);
        info_o.mult  = rtype && (fn inside {F_MULT, F_MULTU});
        info_o.div   = rtype && (fn inside {F_DIV, F_DIVU});
        info_o.isMD  = info_o.mult || info_o.div
                     || (rtype && (fn inside {F_MTHI, F_MTLO}));
        info_o.isMfhilo = rtype && (fn inside {F_MFHI, F_MFLO});

        unique case (1'b1)
            info_o.cal_r, info_o.isMfhilo: info_o.wdes = ins_i[15:11];
            info_o.cal_i, info_o.load:     info_o.wdes = ins_i[20:16];
            info_o.jal:                    info_o.wdes = 5'd31;
            default:                       info_o.wdes = 5'd0;
        endcase
    end

endmodule

// File: rtl/md_busy_counter.sv
// HI/LO busy countdown: reloads when mult/div leaves E,
// then counts down to zero.
module md_busy_counter #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start_mult,
    input  logic start_div,
    output logic busy
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // a fresh start always reloads, even mid-countdown
    always_comb begin
        cnt_d = cnt_q;
        if (start_div) begin
            cnt_d = CNT_W'(DIV_CYCLES);
        end else if (start_mult) begin
            cnt_d = CNT_W'(MULT_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = reset && (start_mult || start_div || (cnt_q != '0));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// D-stage stall/flush decision from Tuse/Tnew and HI/LO busy,
// plus a saturating stalled-cycle counter.
module hazard_stall_ctrl
    import mips_defs::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] INS_D,
    input  logic [31:0] INS_E,
    input  logic [31:0] INS_M,
    output logic        en_PC,
    output logic        en_D,
    output logic        flush_E,
    output logic        stall,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);

    ins_info_t d;
    ins_info_t e;
    ins_info_t m;
    logic      unused_info;

    InsJudge u_jd (.ins_i(INS_D), .info_o(d));
    InsJudge u_je (.ins_i(INS_E), .info_o(e));
    InsJudge u_jm (.ins_i(INS_M), .info_o(m));

    assign unused_info = ^{d, e, m};

    logic [1:0] tuse_rs;
    logic [1:0] tuse_rt;
    logic [1:0] tnew_e;
    logic [1:0] tnew_m;

    always_comb begin
        tuse_rs = T_NONE;
        unique case (1'b1)
            d.beq, d.bgezall, d.jr: tuse_rs = T_0;
            d.cal_r, d.cal_i, d.load,
            d.store, d.isMD:        tuse_rs = T_1;
            default: ;
        endcase
        tuse_rt = T_NONE;
        unique case (1'b1)
            d.beq:          tuse_rt = T_0;
            d.cal_r, d.isMD: tuse_rt = T_1;
            d.store:        tuse_rt = T_2;
            default: ;
        endcase
        tnew_e = T_0;
        unique case (1'b1)
            e.cal_r, e.cal_i, e.isMfhilo: tnew_e = T_1;
            e.load:                       tnew_e = T_2;
            default: ;
        endcase
        tnew_m = m.load ? T_1 : T_0;
    end

    function automatic logic hz(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] des,
        input logic [1:0] tnew
    );
        return (src != 5'd0) && (src == des) && (tuse < tnew);
    endfunction

    logic data_stall;
    logic md_stall;

    assign data_stall = hz(d.rs, tuse_rs, e.wdes, tnew_e)
                      | hz(d.rt, tuse_rt, e.wdes, tnew_e)
                      | hz(d.rs, tuse_rs, m.wdes, tnew_m)
                      | hz(d.rt, tuse_rt, m.wdes, tnew_m);

    md_busy_counter #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_md (
        .clk       (clk),
        .reset     (reset),
        .start_mult(e.mult),
        .start_div (e.div),
        .busy      (md_busy)
    );

    assign md_stall = (d.isMD || d.isMfhilo) && md_busy;
    assign stall    = reset && (data_stall || md_stall);
    assign en_PC    = !stall;
    assign en_D     = !stall;
    assign flush_E  = stall;

    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed pipeline scenarios plus
// random instruction triples against a class-level reference model.
module tb_hazard_stall_ctrl;

    typedef enum int {
        K_NOP, K_ADDU, K_SUBU, K_OR, K_SLT, K_ORI, K_ADDIU, K_LUI,
        K_LW, K_LB, K_SW, K_SB, K_BEQ, K_BGEZALL, K_JR, K_JAL,
        K_MULT, K_MULTU, K_DIV, K_DIVU, K_MFHI, K_MFLO, K_MTHI, K_MTLO
    } kind_t;

    typedef struct {
        kind_t      k;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
    } ins_t;

    logic        clk;
    logic        reset;
    logic [31:0] INS_D;
    logic [31:0] INS_E;
    logic [31:0] INS_M;
    logic        en_PC;
    logic        en_D;
    logic        flush_E;
    logic        stall;
    logic        md_busy;
    logic [31:0] stall_cnt;

    hazard_stall_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .INS_D    (INS_D),
        .INS_E    (INS_E),
        .INS_M    (INS_M),
        .en_PC    (en_PC),
        .en_D     (en_D),
        .flush_E  (flush_E),
        .stall    (stall),
        .md_busy  (md_busy),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    int          md_left = 0;
    logic [31:0] cnt_m = '0;
    ins_t        id, ie, im;

    task automatic check_eq(input string tag,
                            input logic [31:0] obs,
                            input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)",
                     tag, obs, exp, $time);
        end
    endtask

    function automatic ins_t make(kind_t k, int rs, int rt, int rd);
        ins_t i;
        i.k  = k;
        i.rs = 5'(rs);
        i.rt = 5'(rt);
        i.rd = 5'(rd);
        case (k)
            K_NOP, K_JAL: begin i.rs = 0; i.rt = 0; i.rd = 0; end
            K_ORI, K_ADDIU, K_LW, K_LB, K_SW, K_SB, K_BEQ: i.rd = 0;
            K_LUI: begin i.rs = 0; i.rd = 0; end
            K_BGEZALL: begin i.rt = 5'h13; i.rd = 0; end
            K_JR, K_MTHI, K_MTLO: begin i.rt = 0; i.rd = 0; end
            K_MULT, K_MULTU, K_DIV, K_DIVU: i.rd = 0;
            K_MFHI, K_MFLO: begin i.rs = 0; i.rt = 0; end
            default: ;
        endcase
        return i;
    endfunction

    function automatic logic [31:0] enc(ins_t i);
        logic [5:0] op;
        logic [5:0] fn;
        op = 6'h00;
        fn = 6'h00;
        case (i.k)
            K_ADDU:    fn = 6'h21;
            K_SUBU:    fn = 6'h23;
            K_OR:      fn = 6'h25;
            K_SLT:     fn = 6'h2a;
            K_JR:      fn = 6'h08;
            K_MULT:    fn = 6'h18;
            K_MULTU:   fn = 6'h19;
            K_DIV:     fn = 6'h1a;
            K_DIVU:    fn = 6'h1b;
            K_MFHI:    fn = 6'h10;
            K_MTHI:    fn = 6'h11;
            K_MFLO:    fn = 6'h12;
            K_MTLO:    fn = 6'h13;
            K_ORI:     op = 6'h0d;
            K_ADDIU:   op = 6'h09;
            K_LUI:     op = 6'h0f;
            K_LW:      op = 6'h23;
            K_LB:      op = 6'h20;
            K_SW:      op = 6'h2b;
            K_SB:      op = 6'h28;
            K_BEQ:     op = 6'h04;
            K_BGEZALL: op = 6'h01;
            K_JAL:     op = 6'h03;
            default: ;
        endcase
        if (i.k == K_NOP) return 32'h0;
        if (i.k == K_JAL) return {op, 26'h10};
        if (op == 6'h00) return {op, i.rs, i.rt, i.rd, 5'h0, fn};
        return {op, i.rs, i.rt, 16'h0005};
    endfunction

    function automatic bit is_calr(kind_t k);
        return k inside {K_ADDU, K_SUBU, K_OR, K_SLT};
    endfunction
    function automatic bit is_cali(kind_t k);
        return k inside {K_ORI, K_ADDIU, K_LUI};
    endfunction
    function automatic bit is_load(kind_t k);
        return k inside {K_LW, K_LB};
    endfunction
    function automatic bit is_store(kind_t k);
        return k inside {K_SW, K_SB};
    endfunction
    function automatic bit is_mdop(kind_t k);
        return k inside {K_MULT, K_MULTU, K_DIV, K_DIVU, K_MTHI, K_MTLO};
    endfunction

    function automatic int tuse_rs(kind_t k);
        if (k inside {K_BEQ, K_BGEZALL, K_JR}) return 0;
        if (is_calr(k) || is_cali(k) || is_load(k) || is_store(k)
            || is_mdop(k)) return 1;
        return 99;
    endfunction

    function automatic int tuse_rt(kind_t k);
        if (k == K_BEQ) return 0;
        if (is_calr(k) || is_mdop(k)) return 1;
        if (is_store(k)) return 2;
        return 99;
    endfunction

    function automatic int tnew_e(kind_t k);
        if (is_calr(k) || is_cali(k) || k inside {K_MFHI, K_MFLO})
            return 1;
        if (is_load(k)) return 2;
        return 0;
    endfunction

    function automatic int tnew_m(kind_t k);
        return is_load(k) ? 1 : 0;
    endfunction

    function automatic int dest(ins_t i);
        if (is_calr(i.k) || i.k inside {K_MFHI, K_MFLO}) return i.rd;
        if (is_cali(i.k) || is_load(i.k)) return i.rt;
        if (i.k == K_JAL) return 31;
        return 0;
    endfunction

    function automatic bit data_hz(ins_t d, ins_t e, ins_t m);
        int src[2];
        int tu[2];
        src[0] = d.rs;
        src[1] = d.rt;
        tu[0]  = tuse_rs(d.k);
        tu[1]  = tuse_rt(d.k);
        for (int s = 0; s < 2; s++) begin
            if (src[s] != 0) begin
                if (dest(e) == src[s] && tu[s] < tnew_e(e.k)) return 1;
                if (dest(m) == src[s] && tu[s] < tnew_m(m.k)) return 1;
            end
        end
        return 0;
    endfunction

    task automatic set_ins(ins_t d, ins_t e, ins_t m);
        id    = d;
        ie    = e;
        im    = m;
        INS_D = enc(d);
        INS_E = enc(e);
        INS_M = enc(m);
    endtask

    // called just after a falling edge with inputs already applied
    task automatic run_cycle(input int want_stall);
        bit exp_busy;
        bit exp_st;
        #1;
        exp_busy = (ie.k inside {K_MULT, K_MULTU, K_DIV, K_DIVU})
                 || (md_left > 0);
        exp_st = data_hz(id, ie, im)
               || ((is_mdop(id.k) || id.k inside {K_MFHI, K_MFLO})
                   && exp_busy);
        check_eq("stall", stall, exp_st);
        check_eq("en_PC", en_PC, !exp_st);
        check_eq("en_D", en_D, !exp_st);
        check_eq("flush_E", flush_E, exp_st);
        check_eq("md_busy", md_busy, exp_busy);
        check_eq("stall_cnt", stall_cnt, cnt_m);
        if (want_stall >= 0) check_eq("directed_stall", stall, 32'(want_stall));
        @(posedge clk);
        if (exp_st && cnt_m != 32'hFFFF_FFFF) cnt_m = cnt_m + 1;
        if (ie.k inside {K_MULT, K_MULTU}) md_left = 5;
        else if (ie.k inside {K_DIV, K_DIVU}) md_left = 10;
        else if (md_left > 0) md_left--;
        @(negedge clk);
    endtask

    task automatic chk_reset();
        check_eq("rst_en_PC", en_PC, 1);
        check_eq("rst_en_D", en_D, 1);
        check_eq("rst_flush_E", flush_E, 0);
        check_eq("rst_stall", stall, 0);
        check_eq("rst_md_busy", md_busy, 0);
        check_eq("rst_stall_cnt", stall_cnt, 0);
    endtask

    ins_t nop;

    initial begin
        nop   = make(K_NOP, 0, 0, 0);
        reset = 1'b0;
        set_ins(make(K_ADDU, 1, 3, 2), make(K_LW, 0, 1, 0), nop);
        #2;
        chk_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // load-use: one stall, then forwardable from M
        set_ins(make(K_ADDU, 1, 3, 2), make(K_LW, 0, 1, 0), nop);
        run_cycle(1);
        set_ins(make(K_ADDU, 1, 3, 2), nop, make(K_LW, 0, 1, 0));
        run_cycle(0);

        // branch needs operands in D
        set_ins(make(K_BEQ, 1, 2, 0), make(K_ADDU, 2, 3, 1), nop);
        run_cycle(1);
        set_ins(make(K_BEQ, 1, 2, 0), nop, make(K_LW, 0, 1, 0));
        run_cycle(1);

        // $0 never creates a dependency
        set_ins(make(K_ADDU, 0, 0, 2), make(K_ORI, 0, 0, 0), nop);
        run_cycle(0);

        // mult at t, mflo waiting from t+1
        set_ins(nop, make(K_MULT, 1, 2, 0), nop);
        run_cycle(0);
        for (int c = 1; c <= 5; c++) begin
            set_ins(make(K_MFLO, 0, 0, 4), nop, nop);
            run_cycle(1);
        end
        set_ins(make(K_MFLO, 0, 0, 4), nop, nop);
        run_cycle(0);

        // reset in the middle of a div countdown
        set_ins(nop, make(K_DIV, 1, 2, 0), nop);
        run_cycle(0);
        for (int c = 1; c <= 2; c++) begin
            set_ins(make(K_MFLO, 0, 0, 4), nop, nop);
            run_cycle(1);
        end
        set_ins(make(K_MULT, 1, 2, 0), make(K_LW, 0, 1, 0), nop);
        reset   = 1'b0;
        md_left = 0;
        cnt_m   = '0;
        #1;
        chk_reset();
        @(posedge clk);
        #1;
        chk_reset();
        @(negedge clk);
        reset = 1'b1;
        set_ins(make(K_MFLO, 0, 0, 4), nop, nop);
        run_cycle(0);

        // random triples
        for (int n = 0; n < 600; n++) begin
            ins_t rd_d, rd_e, rd_m;
            rd_d = make(kind_t'($urandom_range(0, 23)), $urandom_range(0, 3),
                        $urandom_range(0, 3), $urandom_range(0, 3));
            rd_e = make(kind_t'($urandom_range(0, 23)), $urandom_range(0, 3),
                        $urandom_range(0, 3), $urandom_range(0, 3));
            rd_m = make(kind_t'($urandom_range(0, 23)), $urandom_range(0, 3),
                        $urandom_range(0, 3), $urandom_range(0, 3));
            if (rd_e.k inside {K_MULT, K_MULTU, K_DIV, K_DIVU}
                && $urandom_range(0, 3) != 0) rd_e = nop;
            set_ins(rd_d, rd_e, rd_m);
            run_cycle(-1);
        end

        // counter saturation near the top of its range
        set_ins(make(K_ADDU, 1, 3, 2), make(K_LW, 0, 1, 0), nop);
        force dut.stall_cnt_q = 32'hFFFF_FFFD;
        #1;
        release dut.stall_cnt_q;
        cnt_m = 32'hFFFF_FFFD;
        for (int c = 0; c < 5; c++) begin
            run_cycle(1);
        end
        #1;
        check_eq("sat_hold", stall_cnt, 32'hFFFF_FFFF);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
